lsuc_uart_rx: RTL

Serial receiver for the lsuc UART link: recovers 8N1 frames from the `rx` pin and presents each byte through a hold-until-read register. It is the receiving end of the `tx`→`rx` serial pair at the `lsuc_top` pins. The chip's serial transmitter is looped straight into this block in the top-level bench, so the frame format and bit period match the transmitter exactly.

---
 rtl/lsuc_uart_rx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lsuc_uart_rx.sv
// lsuc_uart_rx -- 8N1 serial receiver with a hold-until-read byte register.
//
// Recovers frames from the asynchronous rx pin. The start bit is verified at
// mid-bit. Data bits are sampled at mid-bit, LSB first. A high stop bit
// delivers the byte and a low stop bit reports a framing error.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   rx            asynchronous serial input, idle high
//   rx_data       last delivered byte
//   rx_valid      rx_data holds an unread byte
//   rx_read       single-cycle pulse consuming rx_data
//   rx_overrun    sticky: a byte arrived while rx_valid was already high
//   rx_frame_err  one-cycle pulse: stop bit sampled low
//   rx_busy       receiver FSM is not idle
`timescale 1ns/1ps

module lsuc_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 278
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_read,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    logic          rx_meta_q, rx_s_q;
    logic [1:0]    settle_q;
    logic          armed_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          deliver;

    // The synchronizer resets to idle-high, so right after reset a line that
    // is already low would look like a fresh falling edge. Reception is only
    // armed once rx_s has carried a real post-reset sample that is high. This
    // stops a frame interrupted by reset from being picked up mid-way.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            settle_q  <= {settle_q[0], 1'b1};
            if (settle_q[1] && rx_s_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ferr_d    = 1'b0;
        deliver   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A read consumes the byte; a simultaneous delivery then re-fills it,
        // so delivery takes priority over the read for rx_valid.
        if (rx_read && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_read) begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;

endmodule
